// File: rtl/rd_resp_pkg.sv
// rd_resp_pkg: shared definitions for the rd_responder read target.
//   state_t    - responder FSM states, each tracking an initiator phase
//   CNT_W      - width of the wait-state down-counter
//   LFSR_TAPS  - tap mask for the x^4+x^3+1 Fibonacci LFSR
//   lfsr_next  - one LFSR step (shift left, XOR of tapped bits enters at bit 0)
package rd_resp_pkg;

   localparam int unsigned CNT_W = 4;

   localparam logic [3:0] LFSR_TAPS = 4'b1100;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DLYPH = 2'd1,
      RDPH  = 2'd2,
      FIN   = 2'd3
   } state_t;

   function automatic logic [3:0] lfsr_next(input logic [3:0] v);
      return {v[2:0], ^(v & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/rd_resp_lfsr.sv
// rd_resp_lfsr: 4-bit Fibonacci LFSR (x^4+x^3+1) that supplies per-read wait
// counts. The two low bits are presented before the advance, so the value
// used by a read is the one held before that read's accept edge.
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset, loads SEED
//   i_adv  in   advance one step on this edge
//   o_low  out  current LFSR[1:0]
module rd_resp_lfsr
   import rd_resp_pkg::*;
#(
   parameter logic [3:0] SEED = 4'h9
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_adv,
   output logic [1:0] o_low
);

   logic [3:0] r_lfsr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr <= SEED;
      end else if (i_adv) begin
         r_lfsr <= lfsr_next(r_lfsr);
      end
   end

   assign o_low = r_lfsr[1:0];

endmodule

// File: rtl/rd_responder.sv
// rd_responder: target-side partner of the rd/ws/ds read initiator. It samples
// rd/addr, inserts wait states on ws, and returns data from a small register
// file with a one-cycle rvalid aligned to the initiator's DONE cycle.
// A side write port loads the register file independently of the FSM.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset (also clears the array)
//   rd         in   read strobe from the initiator
//   addr       in   read address, captured on the first rd=1 cycle
//   ws         out  wait-state request (meaningful in DLYPH cycles)
//   rdata      out  read data, held until the next rvalid
//   rvalid     out  one-cycle read-complete pulse
//   abort_err  out  one-cycle protocol-error pulse (rd dropped early, or rd in FIN)
//   busy       out  high whenever the FSM is not in IDLE
//   we         in   register-file write enable
//   waddr      in   register-file write address
//   wdata      in   register-file write data
//
// Build option: define RD_RESPONDER_LFSR_WAIT_EN to take each read's wait
// count from an LFSR (0..3) instead of WAIT_CYCLES.
module rd_responder
   import rd_resp_pkg::*;
#(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned ADDR_W      = 4,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [3:0]  LFSR_SEED   = 4'h9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd,
   input  logic [ADDR_W-1:0] addr,
   output logic              ws,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic              abort_err,
   output logic              busy,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_addr_q;
   logic              r_ws;
   logic              r_rvalid;
   logic              r_abort;
   logic              r_busy;
   logic [DATA_W-1:0] r_rdata;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [CNT_W-1:0]  w_wait_init;

`ifdef RD_RESPONDER_LFSR_WAIT_EN
   logic       w_accept;
   logic [1:0] w_lfsr_low;

   assign w_accept = (r_state == IDLE) && rd;

   rd_resp_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .i_adv (w_accept),
      .o_low (w_lfsr_low)
   );

   assign w_wait_init = {2'b00, w_lfsr_low};
`else
   // The seed only matters when the LFSR is built in.
   logic w_unused_seed;
   assign w_unused_seed = ^LFSR_SEED;

   assign w_wait_init = CNT_W'(WAIT_CYCLES);
`endif

   // Responder FSM. Each DLYPH/RDPH pair mirrors one DLY/READ loop of the
   // initiator; cnt counts the remaining ws=1 samples still to be given.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_addr_q <= '0;
         r_ws     <= 1'b0;
         r_rvalid <= 1'b0;
         r_abort  <= 1'b0;
         r_busy   <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_rvalid <= 1'b0;
         r_abort  <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (rd) begin
                  r_addr_q <= addr;
                  r_cnt    <= w_wait_init;
                  r_ws     <= (w_wait_init != '0);
                  r_state  <= DLYPH;
                  r_busy   <= 1'b1;
               end
            end
            DLYPH: begin
               if (!rd) begin
                  r_abort <= 1'b1;
                  r_ws    <= 1'b0;
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else if (r_cnt != '0) begin
                  r_cnt   <= r_cnt - CNT_W'(1);
                  r_ws    <= 1'b0;
                  r_state <= RDPH;
               end else begin
                  // Write to the same entry on this edge is not seen here.
                  r_rdata  <= r_mem[r_addr_q];
                  r_rvalid <= 1'b1;
                  r_ws     <= 1'b0;
                  r_state  <= FIN;
               end
            end
            RDPH: begin
               if (!rd) begin
                  r_abort <= 1'b1;
                  r_ws    <= 1'b0;
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_ws    <= (r_cnt != '0);
                  r_state <= DLYPH;
               end
            end
            FIN: begin
               // rd here means the initiator skipped its DONE gap: flag it and
               // refuse to start a read from this cycle.
               r_abort <= rd;
               r_ws    <= 1'b0;
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   assign ws        = r_ws;
   assign rdata     = r_rdata;
   assign rvalid    = r_rvalid;
   assign abort_err = r_abort;
   assign busy      = r_busy;

endmodule
